ysyx_22050019_axi_sram: RTL and testbench
=========================================

# ysyx_22050019_axi_sram

AXI-lite style memory slave directly downstream of the load/store unit. Accepts the LSU's independent read (AR/R) and write (AW/W/B) channels, holds a word-addressed 64-bit array with byte strobes, and returns data and responses with a fixed, parameterised latency. Serves as the data-memory endpoint in simulation and the basis for a later bus-arbiter target.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width (fixed 64; strobe width DATA_W/8)
- DEPTH, 4096, array depth in 64-bit words
- BASE, 64'h8000_0000, first mapped byte address
- RD_LAT, 2, cycles from AR handshake to r_valid (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ar_valid  in  1  read address valid
- ar_ready  out  1  read address accepted
- ar_addr  in  64  read byte address
- r_valid  out  1  read data valid
- r_ready  in  1  read data accepted
- r_data  out  64  read data, full aligned word
- r_resp  out  2  read response
- aw_valid  in  1  write address valid
- aw_ready  out  1  write address accepted
- aw_addr  in  64  write byte address
- w_valid  in  1  write data valid
- w_ready  out  1  write data accepted
- w_data  in  64  write data, already lane-aligned
- w_strb  in  8  byte enables
- b_valid  out  1  write response valid
- b_ready  in  1  write response accepted
- b_resp  out  2  write response

## Operation
- Word index = (addr − BASE) >> 3; addr[2:0] ignored (LSU performs lane shifting). In range iff BASE ≤ addr < BASE + DEPTH·8.
- Read FSM R_IDLE → R_WAIT → R_RESP → R_IDLE.
  - R_IDLE: ar_ready=1; on ar_valid latch address, load counter, go R_WAIT.
  - R_WAIT: counter decrements; at zero sample array into r_data, go R_RESP.
  - R_RESP: r_valid=1, r_data/r_resp held stable until r_ready; then R_IDLE.
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: aw_ready=1; on aw_valid latch address → W_DATA.
  - W_DATA: w_ready=1; on w_valid write bytes where w_strb[i]=1, → W_RESP.
  - W_RESP: b_valid=1 until b_ready → W_IDLE.
- Out of range: read returns r_data=0, r_resp=2'b11 (DECERR); write discarded, b_resp=2'b11. Otherwise resp 2'b00.
- Read and write channels fully independent; both may be active concurrently.

## Timing
- Reset: all FSMs idle; ar_ready, aw_ready, w_ready, r_valid, b_valid = 0 while rst=1; r_data=0, r_resp=0, b_resp=0. Array contents not reset. ar_ready/aw_ready rise the first cycle after rst falls.
- Read latency: AR handshake at edge N → r_valid high in cycle N+RD_LAT.
- Write: AW handshake edge N → w_ready high cycle N+1; W handshake edge M commits data at M, b_valid high cycle M+1.
- ar_ready is 0 from handshake until r handshake completes (one outstanding read); same for aw_ready/writes.
- Read/write hazard: write committed on an edge strictly before the read sample edge is visible; same-edge write is not (old data returned).
- r_ready/b_ready held low while valid is high: outputs hold indefinitely, no data change.
- rst mid-transaction: FSMs abort to idle next edge, in-flight read/write response dropped; a write whose W handshake already occurred stays committed.

## Configuration
- SRAM_RAND_DELAY_EN defined: 8-bit Galois LFSR (taps x^8+x^6+x^5+x^4+1, seed 8'hA5, advances every cycle) adds lfsr[1:0] (0–3) extra cycles to each read latency and delays w_ready in W_DATA by lfsr[3:2] cycles, sampled at the respective address handshake.
- Undefined: latencies exactly as in Timing; no LFSR logic present.

## Structure
- Shared package ysyx_22050019_axi_pkg: RESP_OKAY=2'b00, RESP_DECERR=2'b11, read/write FSM state encodings.
- One sub-module: ysyx_22050019_lfsr8 (instantiated only under SRAM_RAND_DELAY_EN).

## Test plan
- Write aw_addr=0x8000_0008, w_data=0x1122334455667788, w_strb=0xFF; read same → r_data=0x1122334455667788, r_resp=0, r_valid exactly 2 cycles after AR handshake.
- Partial write w_strb=0x0F, w_data=0xAAAA_AAAA_BBBB_BBBB over 0x1122334455667788 → read returns 0x11223344BBBBBBBB.
- Read 0x7FFF_FFF8 and write 0x8000_8000 → r_resp=2'b11, r_data=0; b_resp=2'b11, array unchanged.
- Hold r_ready=0 for 5 cycles after r_valid → r_valid, r_data stable, ar_ready=0 throughout; ready=1 → r_valid low next cycle, ar_ready high.
- Concurrent read 0x8000_0010 and write 0x8000_0018 launched same cycle → both complete, responses OKAY, no interference.
- Assert rst in R_WAIT → next cycle r_valid=0, ar_ready=0; after rst release ar_ready=1, new read succeeds.

Source files
------------

// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared definitions for the ysyx_22050019 AXI-lite memory slave.
//   RESP_OKAY / RESP_DECERR : response codes on r_resp / b_resp
//   r_state_t / w_state_t   : read and write channel FSM encodings
package ysyx_22050019_axi_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
endpackage

// File: rtl/ysyx_22050019_lfsr8.sv
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5.
// Advances every clock; used to jitter the memory slave latencies.
//   clk  : clock
//   rst  : synchronous active-high reset (reloads seed)
//   lfsr : current LFSR state
module ysyx_22050019_lfsr8 (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] lfsr
);
   always_ff @(posedge clk) begin
      if (rst) lfsr <= 8'hA5;
      else     lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
   end
endmodule

// File: rtl/ysyx_22050019_axi_sram.sv
// AXI-lite style 64-bit data memory slave behind the LSU.
// Independent read (AR/R) and write (AW/W/B) channels, one outstanding
// transaction per channel, byte strobes, fixed read latency RD_LAT.
// Addresses outside [BASE, BASE+DEPTH*8) answer DECERR (reads return 0,
// writes are discarded).
// Optional feature: define SRAM_RAND_DELAY_EN to add LFSR-driven extra
// read latency (0-3 cycles) and w_ready delay (0-3 cycles).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   ar_valid/ar_ready/ar_addr         : read address channel
//   r_valid/r_ready/r_data/r_resp     : read data channel
//   aw_valid/aw_ready/aw_addr         : write address channel
//   w_valid/w_ready/w_data/w_strb     : write data channel
//   b_valid/b_ready/b_resp            : write response channel
//
// state  | meaning
// R_IDLE | ar_ready high, waiting for a read address
// R_WAIT | latency counter running down to the array sample
// R_RESP | r_valid high, data held until r_ready
// W_IDLE | aw_ready high, waiting for a write address
// W_DATA | waiting (optionally delayed) for the write data beat
// W_RESP | b_valid high until b_ready
module ysyx_22050019_axi_sram
   import ysyx_22050019_axi_pkg::*;
#(
   parameter int                ADDR_W = 64,
   parameter int                DATA_W = 64,
   parameter int                DEPTH  = 4096,
   parameter logic [ADDR_W-1:0] BASE   = 64'h8000_0000,
   parameter int                RD_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ar_valid,
   output logic                ar_ready,
   input  logic [ADDR_W-1:0]   ar_addr,
   output logic                r_valid,
   input  logic                r_ready,
   output logic [DATA_W-1:0]   r_data,
   output logic [1:0]          r_resp,
   input  logic                aw_valid,
   output logic                aw_ready,
   input  logic [ADDR_W-1:0]   aw_addr,
   input  logic                w_valid,
   output logic                w_ready,
   input  logic [DATA_W-1:0]   w_data,
   input  logic [DATA_W/8-1:0] w_strb,
   output logic                b_valid,
   input  logic                b_ready,
   output logic [1:0]          b_resp
);
   localparam int                IDX_W  = $clog2(DEPTH);
   localparam int                STRB_W = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LIMIT  = BASE + (ADDR_W'(DEPTH) << 3);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] ar_off, aw_off;
   logic              ar_in, aw_in;
   logic [IDX_W-1:0]  ar_idx, aw_idx;
   logic              unused_addr;

   assign ar_off = ar_addr - BASE;
   assign aw_off = aw_addr - BASE;
   assign ar_in  = (ar_addr >= BASE) && (ar_addr < LIMIT);
   assign aw_in  = (aw_addr >= BASE) && (aw_addr < LIMIT);
   assign ar_idx = ar_off[IDX_W+2:3];
   assign aw_idx = aw_off[IDX_W+2:3];
   // Byte lane bits are ignored (the LSU shifts lanes); high bits only
   // matter through the range check.
   assign unused_addr = ^{ar_off[ADDR_W-1:IDX_W+3], ar_off[2:0],
                          aw_off[ADDR_W-1:IDX_W+3], aw_off[2:0]};

   logic [1:0] rd_extra, w_extra;
`ifdef SRAM_RAND_DELAY_EN
   logic [7:0] lfsr;
   logic       unused_lfsr;
   ysyx_22050019_lfsr8 u_lfsr (.clk(clk), .rst(rst), .lfsr(lfsr));
   assign rd_extra    = lfsr[1:0];
   assign w_extra     = lfsr[3:2];
   assign unused_lfsr = ^lfsr[7:4];
`else
   assign rd_extra = 2'd0;
   assign w_extra  = 2'd0;
`endif

   // Cycles spent in R_WAIT before the array sample; zero means the
   // sample happens on the AR handshake edge itself.
   logic [7:0] rd_wait;
   assign rd_wait = 8'(RD_LAT - 1) + {6'd0, rd_extra};

   // ---------------- read channel ----------------
   r_state_t         r_state;
   logic [7:0]       r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic             r_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= R_IDLE;
         ar_ready <= 1'b0;
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_resp   <= RESP_OKAY;
         r_cnt    <= 8'd0;
         r_idx    <= '0;
         r_ok     <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               ar_ready <= 1'b1;
               if (ar_valid && ar_ready) begin
                  ar_ready <= 1'b0;
                  r_idx    <= ar_idx;
                  r_ok     <= ar_in;
                  if (rd_wait == 8'd0) begin
                     r_data  <= ar_in ? mem[ar_idx] : '0;
                     r_resp  <= ar_in ? RESP_OKAY : RESP_DECERR;
                     r_valid <= 1'b1;
                     r_state <= R_RESP;
                  end else begin
                     r_cnt   <= rd_wait - 8'd1;
                     r_state <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               if (r_cnt == 8'd0) begin
                  r_data  <= r_ok ? mem[r_idx] : '0;
                  r_resp  <= r_ok ? RESP_OKAY : RESP_DECERR;
                  r_valid <= 1'b1;
                  r_state <= R_RESP;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            R_RESP: begin
               if (r_ready) begin
                  r_valid  <= 1'b0;
                  ar_ready <= 1'b1;
                  r_state  <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // ---------------- write channel ----------------
   w_state_t         w_state;
   logic [1:0]       w_cnt;
   logic [IDX_W-1:0] w_idx;
   logic             w_ok;
   logic             w_fire;

   assign w_fire = (w_state == W_DATA) && w_ready && w_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state  <= W_IDLE;
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         b_valid  <= 1'b0;
         b_resp   <= RESP_OKAY;
         w_cnt    <= 2'd0;
         w_idx    <= '0;
         w_ok     <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               aw_ready <= 1'b1;
               if (aw_valid && aw_ready) begin
                  aw_ready <= 1'b0;
                  w_idx    <= aw_idx;
                  w_ok     <= aw_in;
                  w_cnt    <= w_extra;
                  w_ready  <= (w_extra == 2'd0);
                  w_state  <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_ready) begin
                  if (w_valid) begin
                     w_ready <= 1'b0;
                     b_valid <= 1'b1;
                     b_resp  <= w_ok ? RESP_OKAY : RESP_DECERR;
                     w_state <= W_RESP;
                  end
               end else begin
                  if (w_cnt == 2'd1) w_ready <= 1'b1;
                  w_cnt <= w_cnt - 2'd1;
               end
            end
            W_RESP: begin
               if (b_ready) begin
                  b_valid  <= 1'b0;
                  aw_ready <= 1'b1;
                  w_state  <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Array is never reset; a W beat accepted before reset stays committed.
   always_ff @(posedge clk) begin
      if (!rst && w_fire && w_ok) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (w_strb[i]) mem[w_idx][i*8 +: 8] <= w_data[i*8 +: 8];
         end
      end
   end
endmodule

// File: tb/tb_ysyx_22050019_axi_sram.sv
module tb_ysyx_22050019_axi_sram;
   localparam logic [63:0] BASE   = 64'h8000_0000;
   localparam int          DEPTH  = 4096;
   localparam int          RD_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        ar_valid, ar_ready, r_valid, r_ready;
   logic [63:0] ar_addr, r_data;
   logic [1:0]  r_resp;
   logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
   logic [63:0] aw_addr, w_data;
   logic [7:0]  w_strb;
   logic [1:0]  b_resp;

   always #5 clk = ~clk;

   ysyx_22050019_axi_sram #(.ADDR_W(64), .DATA_W(64), .DEPTH(DEPTH),
                            .BASE(BASE), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
      .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
   );

   int checks = 0;
   int errors = 0;

   logic [63:0] model [int];
   logic [65:0] rq [$];
   logic [1:0]  bq [$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit in_range(input logic [63:0] a);
      return (a >= BASE) && (a < BASE + 64'(DEPTH) * 8);
   endfunction

   function automatic int widx(input logic [63:0] a);
      return int'((a - BASE) / 8);
   endfunction

   // Read-channel monitor
   initial begin
      logic [65:0] e;
      forever begin
         @(negedge clk); #2;
         if (r_valid && r_ready) begin
            if (rq.size() == 0) begin
               chk("r_unexpected", 64'd1, 64'd0);
            end else begin
               e = rq.pop_front();
               chk("r_data", r_data, e[65:2]);
               chk("r_resp", {62'd0, r_resp}, {62'd0, e[1:0]});
            end
         end
      end
   end

   // Write-response monitor
   initial begin
      logic [1:0] e;
      forever begin
         @(negedge clk); #2;
         if (b_valid && b_ready) begin
            if (bq.size() == 0) begin
               chk("b_unexpected", 64'd1, 64'd0);
            end else begin
               e = bq.pop_front();
               chk("b_resp", {62'd0, b_resp}, {62'd0, e});
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
      int n;
      if (in_range(addr)) begin
         logic [63:0] w;
         w = model.exists(widx(addr)) ? model[widx(addr)] : 64'd0;
         for (int i = 0; i < 8; i++) if (strb[i]) w[i*8 +: 8] = data[i*8 +: 8];
         model[widx(addr)] = w;
         bq.push_back(2'b00);
      end else begin
         bq.push_back(2'b11);
      end
      @(negedge clk);
      aw_addr = addr; w_data = data; w_strb = strb;
      aw_valid = 1'b1; w_valid = 1'b1;
      n = 0;
      while (!aw_ready && n < 100) begin @(negedge clk); n++; end
      if (!aw_ready) begin
         chk("aw_timeout", 64'd1, 64'd0);
         aw_valid = 1'b0; w_valid = 1'b0;
         return;
      end
      @(negedge clk);
      aw_valid = 1'b0;
      chk("w_ready_after_aw", {63'd0, w_ready}, 64'd1);
      n = 0;
      while (!w_ready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      w_valid = 1'b0;
      chk("b_valid_after_w", {63'd0, b_valid}, 64'd1);
      n = 0;
      while (b_valid && n < 100) begin @(negedge clk); n++; end
      if (b_valid) chk("b_timeout", 64'd1, 64'd0);
   endtask

   task automatic do_read(input logic [63:0] addr);
      int n;
      if (in_range(addr)) rq.push_back({model[widx(addr)], 2'b00});
      else                rq.push_back({64'd0, 2'b11});
      @(negedge clk);
      ar_addr = addr; ar_valid = 1'b1;
      n = 0;
      while (!ar_ready && n < 100) begin @(negedge clk); n++; end
      if (!ar_ready) begin
         chk("ar_timeout", 64'd1, 64'd0);
         ar_valid = 1'b0;
         return;
      end
      @(negedge clk);
      ar_valid = 1'b0;
      n = 1;
      while (!r_valid && n < 100) begin @(negedge clk); n++; end
      chk("rd_latency", 64'(n), 64'(RD_LAT));
      n = 0;
      while (r_valid && n < 100) begin @(negedge clk); n++; end
      if (r_valid) chk("r_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      logic [63:0] a, d, exp_d;
      int n;
      rst = 1'b1;
      ar_valid = 0; ar_addr = 0; r_ready = 1;
      aw_valid = 0; aw_addr = 0; w_valid = 0; w_data = 0; w_strb = 0; b_ready = 1;
      repeat (3) @(negedge clk);
      chk("rst_ar_ready", {63'd0, ar_ready}, 64'd0);
      chk("rst_aw_ready", {63'd0, aw_ready}, 64'd0);
      chk("rst_w_ready",  {63'd0, w_ready},  64'd0);
      chk("rst_r_valid",  {63'd0, r_valid},  64'd0);
      chk("rst_b_valid",  {63'd0, b_valid},  64'd0);
      chk("rst_r_data",   r_data, 64'd0);
      chk("rst_resps",    {60'd0, r_resp, b_resp}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ar_ready_after_rst", {63'd0, ar_ready}, 64'd1);
      chk("aw_ready_after_rst", {63'd0, aw_ready}, 64'd1);

      for (int i = 0; i < 16; i++)
         do_write(BASE + 64'(i) * 8, {$urandom, $urandom}, 8'hFF);

      // Full-word write/read, then partial strobe merge
      do_write(64'h8000_0008, 64'h1122334455667788, 8'hFF);
      do_read(64'h8000_0008);
      do_write(64'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
      chk("model_partial", model[1], 64'h11223344BBBBBBBB);
      do_read(64'h8000_0008);

      // Out of range: read below BASE, write aliasing word 0 if truncated
      do_read(64'h7FFF_FFF8);
      do_write(64'h8000_0000, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
      do_write(64'h8000_8000, 64'h0123_4567_89AB_CDEF, 8'hFF);
      do_read(64'h8000_0000);

      // Back-pressure on R
      r_ready = 1'b0;
      exp_d = model[2];
      rq.push_back({exp_d, 2'b00});
      @(negedge clk);
      ar_addr = 64'h8000_0010; ar_valid = 1'b1;
      n = 0;
      while (!ar_ready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      ar_valid = 1'b0;
      n = 0;
      while (!r_valid && n < 100) begin @(negedge clk); n++; end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_r_valid",  {63'd0, r_valid},  64'd1);
         chk("stall_r_data",   r_data, exp_d);
         chk("stall_ar_ready", {63'd0, ar_ready}, 64'd0);
      end
      r_ready = 1'b1;
      @(negedge clk);
      chk("release_r_valid",  {63'd0, r_valid},  64'd0);
      chk("release_ar_ready", {63'd0, ar_ready}, 64'd1);

      // Concurrent read and write on different words
      fork
         do_read(64'h8000_0010);
         do_write(64'h8000_0018, 64'hCAFE_F00D_1234_5678, 8'hFF);
      join
      do_read(64'h8000_0018);

      // Reset while the read is waiting
      @(negedge clk);
      ar_addr = 64'h8000_0008; ar_valid = 1'b1;
      n = 0;
      while (!ar_ready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      ar_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_r_valid",  {63'd0, r_valid},  64'd0);
      chk("rst_mid_ar_ready", {63'd0, ar_ready}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_ar_ready_back", {63'd0, ar_ready}, 64'd1);
      do_read(64'h8000_0008);

      // Randomized mix
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) a = BASE - 64'($urandom_range(1, 4)) * 8;
            else a = BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 4)) * 8;
         end else begin
            a = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 1) == 0) begin
            d = {$urandom, $urandom};
            do_write(a, d, 8'($urandom_range(0, 255)));
         end else begin
            do_read(a);
         end
      end

      repeat (5) @(negedge clk);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      chk("bq_drained", 64'(bq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
